// File: rtl/hazard_stall_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit_if
// Description : ID-stage control bundle between the decode stage and the
//               hazard/stall unit: ID operand fields and memory handshake in,
//               stall/freeze controls and tracked destinations out.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] src1_ID;
  logic [REG_ADDR_W-1:0] src2_ID;
  logic                  src2_used_ID;
  logic [REG_ADDR_W-1:0] dest_ID;
  logic                  reg_write_en_ID;
  logic                  mem_read_ID;
  logic                  mem_write_ID;
  logic                  valid_ID;
  logic                  flush;
  logic                  mem_ready;

  logic                  hazard_stall;
  logic                  pipe_freeze;
  logic                  mem_err;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic                  exe_we;
  logic                  mem_we;
  logic                  wb_we;

  // Decode stage / memory side: drives ID fields and handshake, observes controls.
  modport master (
    output src1_ID, src2_ID, src2_used_ID, dest_ID, reg_write_en_ID,
           mem_read_ID, mem_write_ID, valid_ID, flush, mem_ready,
    input  hazard_stall, pipe_freeze, mem_err,
           exe_dest, mem_dest, wb_dest, exe_we, mem_we, wb_we
  );

  // Hazard unit side.
  modport slave (
    input  src1_ID, src2_ID, src2_used_ID, dest_ID, reg_write_en_ID,
           mem_read_ID, mem_write_ID, valid_ID, flush, mem_ready,
    output hazard_stall, pipe_freeze, mem_err,
           exe_dest, mem_dest, wb_dest, exe_we, mem_we, wb_we
  );
endinterface
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Tracks destinations in flight through EXE/MEM/WB, raises
//               RAW stalls at ID and freezes the pipeline while a data-memory
//               access is outstanding (with a sticky timeout error).
//               Build option FORWARD_EN: when defined, a bypass network exists
//               downstream and only load-use against EXE stalls; when
//               undefined, any match against EXE or MEM stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 64,  // must be >= 2
  parameter int TO_W        = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_unit_if.slave  bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  mem_err_q, mem_err_d;
  logic                  mem_done_q, mem_done_d;

  logic [REG_ADDR_W-1:0] exe_dest_q, exe_dest_d;
  logic                  exe_we_q, exe_we_d;
  logic                  exe_mem_q, exe_mem_d;
`ifdef FORWARD_EN
  logic                  exe_load_q, exe_load_d;
`endif
  logic [REG_ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_mem_q, mem_mem_d;
  logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic                  wb_we_q, wb_we_d;

  logic                  s1_exe, s2_exe, raw_hit, stall, freeze, issue;
  logic [TO_W-1:0]       to_cnt_inc;

  // RAW detection at ID; register 0 never matches, src2 only when it is a real operand.
  always_comb begin
    s1_exe  = (bus.src1_ID != '0) & exe_we_q & (bus.src1_ID == exe_dest_q);
    s2_exe  = bus.src2_used_ID & (bus.src2_ID != '0) & exe_we_q &
              (bus.src2_ID == exe_dest_q);
`ifdef FORWARD_EN
    // Bypass covers everything except a load still computing its address in EXE.
    raw_hit = exe_load_q & (s1_exe | s2_exe);
`else
    // No bypass: anything not yet written back (EXE or MEM) must be waited out.
    raw_hit = s1_exe | s2_exe |
              ((bus.src1_ID != '0) & mem_we_q & (bus.src1_ID == mem_dest_q)) |
              (bus.src2_used_ID & (bus.src2_ID != '0) & mem_we_q &
               (bus.src2_ID == mem_dest_q));
`endif
    stall   = bus.valid_ID & ~bus.flush & raw_hit;
    issue   = bus.valid_ID & ~stall & ~bus.flush;
    // Release is combinational on mem_ready so the completing edge also advances.
    freeze  = ((state_q == S_MEM_WAIT) & ~bus.mem_ready) |
              ((state_q == S_RUN) & mem_mem_q & ~bus.mem_ready & ~mem_done_q);
  end

  // Memory-wait FSM and timeout counter next state.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    mem_err_d  = mem_err_q;
    mem_done_d = mem_done_q;
    to_cnt_inc = to_cnt_q + TO_W'(1);
    case (state_q)
      S_RUN: begin
        if (mem_mem_q & ~bus.mem_ready & ~mem_done_q) begin
          state_d  = S_MEM_WAIT;
          to_cnt_d = '0;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = S_RUN;
        end else begin
          to_cnt_d = to_cnt_inc;
          // Give up: flag the error and let the stuck access retire as complete.
          if (to_cnt_inc == TO_LAST) begin
            state_d    = S_RUN;
            mem_err_d  = 1'b1;
            mem_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
    // Once the slot moves out of MEM the done marker has served its purpose.
    if (~freeze) begin
      mem_done_d = 1'b0;
    end
  end

  // Slot shift register: advance unless frozen; EXE takes a bubble when not issuing.
  always_comb begin
    exe_dest_d = exe_dest_q;
    exe_we_d   = exe_we_q;
    exe_mem_d  = exe_mem_q;
`ifdef FORWARD_EN
    exe_load_d = exe_load_q;
`endif
    mem_dest_d = mem_dest_q;
    mem_we_d   = mem_we_q;
    mem_mem_d  = mem_mem_q;
    wb_dest_d  = wb_dest_q;
    wb_we_d    = wb_we_q;
    if (~freeze) begin
      wb_dest_d  = mem_dest_q;
      wb_we_d    = mem_we_q;
      mem_dest_d = exe_dest_q;
      mem_we_d   = exe_we_q;
      mem_mem_d  = exe_mem_q;
      exe_dest_d = issue ? bus.dest_ID : '0;
      exe_we_d   = issue & bus.reg_write_en_ID;
      exe_mem_d  = issue & (bus.mem_read_ID | bus.mem_write_ID);
`ifdef FORWARD_EN
      exe_load_d = issue & bus.mem_read_ID;
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      to_cnt_q   <= '0;
      mem_err_q  <= 1'b0;
      mem_done_q <= 1'b0;
      exe_dest_q <= '0;
      exe_we_q   <= 1'b0;
      exe_mem_q  <= 1'b0;
`ifdef FORWARD_EN
      exe_load_q <= 1'b0;
`endif
      mem_dest_q <= '0;
      mem_we_q   <= 1'b0;
      mem_mem_q  <= 1'b0;
      wb_dest_q  <= '0;
      wb_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      mem_err_q  <= mem_err_d;
      mem_done_q <= mem_done_d;
      exe_dest_q <= exe_dest_d;
      exe_we_q   <= exe_we_d;
      exe_mem_q  <= exe_mem_d;
`ifdef FORWARD_EN
      exe_load_q <= exe_load_d;
`endif
      mem_dest_q <= mem_dest_d;
      mem_we_q   <= mem_we_d;
      mem_mem_q  <= mem_mem_d;
      wb_dest_q  <= wb_dest_d;
      wb_we_q    <= wb_we_d;
    end
  end

  assign bus.hazard_stall = stall;
  assign bus.pipe_freeze  = freeze;
  assign bus.mem_err      = mem_err_q;
  assign bus.exe_dest     = exe_dest_q;
  assign bus.mem_dest     = mem_dest_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.exe_we       = exe_we_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.wb_we        = wb_we_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed scenarios plus randomized traffic against an
//               in-bench model of the hazard/stall unit (MEM_TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

  localparam int TMO = 8;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] dest;
    logic       we;
    logic       ld;
    logic       mm;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_stall_unit_if #(.REG_ADDR_W(5)) bus ();

  hazard_stall_unit #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(TMO),
    .TO_W       (7)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // All observable outputs packed for single-shot comparison.
  function automatic logic [20:0] obs();
    return {bus.hazard_stall, bus.pipe_freeze, bus.mem_err,
            bus.exe_dest, bus.exe_we, bus.mem_dest, bus.mem_we,
            bus.wb_dest, bus.wb_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic s2u, input logic [4:0] d, input logic we,
                        input logic rd, input logic wr);
    bus.valid_ID        = v;
    bus.src1_ID         = s1;
    bus.src2_ID         = s2;
    bus.src2_used_ID    = s2u;
    bus.dest_ID         = d;
    bus.reg_write_en_ID = we;
    bus.mem_read_ID     = rd;
    bus.mem_write_ID    = wr;
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1, 5, 5, 1, 5, 1, 1, 0);
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", obs());
    end
    tick();
    tick();
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_held_clocked: got %h expected 0", obs());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    set_id(1, 1, 2, 1, 5, 1, 1, 0);           // lw r5
    #1;
    n_tests++;
    if (bus.hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL load_issue_nostall: got %b expected 0", bus.hazard_stall);
    end
    tick();
    set_id(1, 5, 6, 1, 7, 1, 0, 0);           // add r7, r5, r6
    #1;
    n = 0;
    while (bus.hazard_stall && n < 6) begin
      n++;
      tick();
    end
    n_tests++;
    if (n !== (FWD ? 1 : 2)) begin
      n_fail++;
      $display("FAIL load_use_stall_cycles: got %0d expected %0d", n, FWD ? 1 : 2);
    end
    n_tests++;
    if (bus.exe_we !== 1'b0 || bus.exe_dest !== 5'd0) begin
      n_fail++;
      $display("FAIL load_use_bubble: got we=%b dest=%0d expected we=0 dest=0",
               bus.exe_we, bus.exe_dest);
    end
    tick();
    n_tests++;
    if (bus.exe_we !== 1'b1 || bus.exe_dest !== 5'd7) begin
      n_fail++;
      $display("FAIL load_use_consumer_enters: got we=%b dest=%0d expected we=1 dest=7",
               bus.exe_we, bus.exe_dest);
    end
  endtask

  task automatic test_zero_and_alu();
    int n;
    do_reset();
    set_id(1, 1, 2, 1, 0, 1, 0, 0);           // add r0
    tick();
    set_id(1, 0, 0, 1, 4, 1, 0, 0);           // consumer of r0
    #1;
    n_tests++;
    if (bus.hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg_nostall: got %b expected 0", bus.hazard_stall);
    end
    tick();
    set_id(1, 1, 2, 0, 3, 1, 0, 0);           // add r3
    tick();
    set_id(1, 3, 2, 1, 6, 1, 0, 0);           // consumer of r3
    #1;
    n = 0;
    while (bus.hazard_stall && n < 6) begin
      n++;
      tick();
    end
    n_tests++;
    if (n !== (FWD ? 0 : 2)) begin
      n_fail++;
      $display("FAIL alu_use_stall_cycles: got %0d expected %0d", n, FWD ? 0 : 2);
    end
  endtask

  task automatic test_mem_freeze();
    do_reset();
    set_id(1, 1, 0, 0, 11, 1, 0, 0);          // add r11
    tick();
    set_id(1, 2, 3, 1, 9, 0, 0, 1);           // store
    tick();
    set_id(1, 4, 0, 0, 12, 1, 0, 0);          // add r12
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (bus.pipe_freeze !== 1'b1 ||
          {bus.exe_dest, bus.mem_dest, bus.wb_dest} !== {5'd12, 5'd9, 5'd11}) begin
        n_fail++;
        $display("FAIL mem_freeze_hold[%0d]: got frz=%b dests=%0d/%0d/%0d expected frz=1 dests=12/9/11",
                 c, bus.pipe_freeze, bus.exe_dest, bus.mem_dest, bus.wb_dest);
      end
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.pipe_freeze !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_release: got %b expected 0", bus.pipe_freeze);
    end
    tick();
    n_tests++;
    if ({bus.exe_dest, bus.mem_dest, bus.wb_dest} !== {5'd0, 5'd12, 5'd9}) begin
      n_fail++;
      $display("FAIL mem_advance: got %0d/%0d/%0d expected 0/12/9",
               bus.exe_dest, bus.mem_dest, bus.wb_dest);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    set_id(1, 1, 2, 1, 9, 0, 0, 1);           // store
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    tick();
    n = 0;
    while (bus.pipe_freeze && n < 20) begin
      n++;
      tick();
    end
    n_tests++;
    if (n !== TMO) begin
      n_fail++;
      $display("FAIL timeout_freeze_cycles: got %0d expected %0d", n, TMO);
    end
    n_tests++;
    if (bus.mem_err !== 1'b1 || bus.mem_dest !== 5'd9) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b mem_dest=%0d expected err=1 mem_dest=9",
               bus.mem_err, bus.mem_dest);
    end
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.mem_err !== 1'b1 || bus.pipe_freeze !== 1'b0 || bus.mem_dest !== 5'd0) begin
      n_fail++;
      $display("FAIL timeout_sticky_resume: got err=%b frz=%b mem_dest=%0d expected 1/0/0",
               bus.mem_err, bus.pipe_freeze, bus.mem_dest);
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    set_id(1, 1, 2, 1, 5, 1, 1, 0);           // lw r5
    tick();
    set_id(1, 5, 5, 1, 8, 1, 0, 0);
    bus.flush = 1'b1;
    #1;
    n_tests++;
    if (bus.hazard_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_kills_stall: got %b expected 0", bus.hazard_stall);
    end
    tick();
    n_tests++;
    if (bus.exe_we !== 1'b0 || bus.exe_dest !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_bubble: got we=%b dest=%0d expected 0/0", bus.exe_we, bus.exe_dest);
    end
    bus.flush = 1'b0;
  endtask

  // Runs with mem_err still set from the timeout scenario.
  task automatic test_async_reset();
    bus.mem_ready = 1'b1;
    set_id(1, 1, 2, 1, 9, 0, 0, 1);           // store
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.mem_ready = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.pipe_freeze !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre_wait: got %b expected 1", bus.pipe_freeze);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got %h expected 0", obs());
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.pipe_freeze !== 1'b0 || bus.mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_release_run: got frz=%b err=%b expected 0/0",
               bus.pipe_freeze, bus.mem_err);
    end
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_random();
    slot_t       m_pipe [3];
    int          m_wait;
    bit          m_served;
    bit          m_err;
    bit          e_haz, e_frz, hit;
    int          low_run;
    logic [20:0] exp_v;
    do_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_wait = 0; m_served = 0; m_err = 0; low_run = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      set_id(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 1'b0, 1'b0);
      case ($urandom_range(0, 5))
        0: bus.mem_read_ID  = 1'b1;
        1: bus.mem_write_ID = 1'b1;
        default: ;
      endcase
      bus.flush = 1'($urandom_range(0, 9) == 0);
      if (low_run == 0 && $urandom_range(0, 40) == 0) low_run = $urandom_range(6, 12);
      if (low_run > 0) begin
        bus.mem_ready = 1'b0;
        low_run--;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 3) != 0);
      end
      #1;
      // Expected controls from the rules: frozen while an unserved access waits.
      e_frz = m_pipe[1].mm && !m_served && !bus.mem_ready;
      e_haz = 1'b0;
      if (bus.valid_ID && !bus.flush) begin
        for (int s = 0; s < (FWD ? 1 : 2); s++) begin
          hit = m_pipe[s].we &&
                ((bus.src1_ID != 0 && bus.src1_ID == m_pipe[s].dest) ||
                 (bus.src2_used_ID && bus.src2_ID != 0 && bus.src2_ID == m_pipe[s].dest));
          if (hit && (!FWD || m_pipe[s].ld)) e_haz = 1'b1;
        end
      end
      exp_v = {e_haz, e_frz, m_err, m_pipe[0].dest, m_pipe[0].we,
               m_pipe[1].dest, m_pipe[1].we, m_pipe[2].dest, m_pipe[2].we};
      n_tests++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle[%0d]: got %h expected %h", cyc, obs(), exp_v);
      end
      @(posedge clk);
      if (e_frz) begin
        m_wait++;
        if (m_wait == TMO) begin
          m_served = 1;
          m_err    = 1;
        end
      end else begin
        m_wait    = 0;
        m_served  = 0;
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        if (bus.valid_ID && !e_haz && !bus.flush)
          m_pipe[0] = '{dest: bus.dest_ID, we: bus.reg_write_en_ID,
                        ld: bus.mem_read_ID, mm: bus.mem_read_ID | bus.mem_write_ID};
        else
          m_pipe[0] = '0;
      end
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_and_alu();
    test_mem_freeze();
    test_timeout();
    test_async_reset();
    test_flush_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
